// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Drives an external 4-bit combinational ALU to execute 8-bit operations.
//   Each command is split into a low-nibble pass and a high-nibble pass; ADD
//   adds a third pass that folds the low-nibble carry into the high nibble.
//   The result, the carry out of bit 7 and the caller tag come back over a
//   valid/ready response channel.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_a, cmd_b, cmd_mode   8-bit operands, mode 00 ADD, 01 AND, 10 OR, 11 NOT A
//   cmd_tag                  opaque tag echoed on the response
//   alu_a, alu_b, alu_mode   nibble operands and mode to the external ALU
//   alu_result               combinational ALU result
//   rsp_valid/rsp_ready      response handshake
//   rsp_result, rsp_carry    8-bit result, carry out of bit 7 (ADD only)
//   rsp_tag                  tag of the completed command
//   rsp_zero                 (ALU_OP_SEQUENCER_ZERO_FLAG_EN only) rsp_result==0
//
// Optional feature macro: ALU_OP_SEQUENCER_ZERO_FLAG_EN

module alu_op_sequencer #(
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [1:0]       cmd_mode,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_mode,
    input  logic [3:0]       alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_carry,
`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
    output logic             rsp_zero,
`endif
    output logic [TAG_W-1:0] rsp_tag
);

    localparam logic [1:0] MODE_ADD = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_CRY,
        S_RSP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic [1:0]       r_mode;
    logic [TAG_W-1:0] r_tag;
    logic [7:0]       r_res;
    logic             r_c_lo;
    logic             r_c_hi;
    logic             r_carry;
    logic             w_is_add;
`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
    logic             r_zero;
`endif

    assign w_is_add   = (r_mode == MODE_ADD);
    assign cmd_ready  = (r_state == S_IDLE) && !rst;
    assign rsp_valid  = (r_state == S_RSP) && !rst;
    assign rsp_result = r_res;
    assign rsp_carry  = r_carry;
    assign rsp_tag    = r_tag;
`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
    assign rsp_zero   = r_zero;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state and ALU drive; the ALU sees zeros whenever it is not in use.
    always_comb begin
        w_next   = r_state;
        alu_a    = 4'h0;
        alu_b    = 4'h0;
        alu_mode = 2'b00;
        case (r_state)
            S_IDLE: if (cmd_valid) w_next = S_LO;
            S_LO: begin
                alu_a    = r_a[3:0];
                alu_b    = r_b[3:0];
                alu_mode = r_mode;
                w_next   = S_HI;
            end
            S_HI: begin
                alu_a    = r_a[7:4];
                alu_b    = r_b[7:4];
                alu_mode = r_mode;
                w_next   = w_is_add ? S_CRY : S_RSP;
            end
            S_CRY: begin
                // Fold the low-nibble carry into the high nibble with one more ADD.
                alu_a    = r_res[7:4];
                alu_b    = {3'b000, r_c_lo};
                alu_mode = MODE_ADD;
                w_next   = S_RSP;
            end
            S_RSP:   if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Holding registers. A 4-bit add wrapped iff its sum is below an operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_mode  <= '0;
            r_tag   <= '0;
            r_res   <= '0;
            r_c_lo  <= 1'b0;
            r_c_hi  <= 1'b0;
            r_carry <= 1'b0;
`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
            r_zero  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_a     <= cmd_a;
                        r_b     <= cmd_b;
                        r_mode  <= cmd_mode;
                        r_tag   <= cmd_tag;
                        r_res   <= '0;
                        r_c_lo  <= 1'b0;
                        r_c_hi  <= 1'b0;
                        r_carry <= 1'b0;
                    end
                end
                S_LO: begin
                    r_res[3:0] <= alu_result;
                    if (w_is_add) r_c_lo <= (alu_result < r_a[3:0]);
                end
                S_HI: begin
                    r_res[7:4] <= alu_result;
                    if (w_is_add) r_c_hi <= (alu_result < r_a[7:4]);
`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
                    else r_zero <= (alu_result == 4'h0) && (r_res[3:0] == 4'h0);
`endif
                end
                S_CRY: begin
                    r_res[7:4] <= alu_result;
                    r_carry    <= r_c_hi | (alu_result < r_res[7:4]);
`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
                    r_zero     <= (alu_result == 4'h0) && (r_res[3:0] == 4'h0);
`endif
                end
                S_RSP: begin
`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
                    if (rsp_ready) r_zero <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  localparam int TAG_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [7:0]       cmd_a = '0, cmd_b = '0;
  logic [1:0]       cmd_mode = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [3:0]       alu_a, alu_b, alu_result;
  logic [1:0]       alu_mode;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [7:0]       rsp_result;
  logic             rsp_carry;
  logic [TAG_W-1:0] rsp_tag;
`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
  logic             rsp_zero;
`endif

  alu_op_sequencer #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_mode(cmd_mode), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
    .rsp_zero(rsp_zero),
`endif
    .rsp_tag(rsp_tag)
  );

  always #5 clk = ~clk;

  // external 4-bit ALU
  always_comb begin
    case (alu_mode)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a & alu_b;
      2'b10:   alu_result = alu_a | alu_b;
      default: alu_result = ~alu_a;
    endcase
  end

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // 8-bit reference: {carry, result}
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    case (m)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a & b};
      2'b10:   return {1'b0, a | b};
      default: return {1'b0, ~a};
    endcase
  endfunction

  // response ready driver
  logic rr_rand = 1'b0, rr_force = 1'b1;
  always @(posedge clk) begin
    #1;
    rsp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_force;
  end

  // scoreboard / compare process
  logic             busy = 1'b0, seen = 1'b0;
  int               acc_cyc = 0, hs_cyc = 0, n_acc = 0, n_rsp = 0, k, lat, last_lat = 0;
  logic [7:0]       ca, cb, last_res;
  logic [1:0]       cm;
  logic [TAG_W-1:0] ct, last_tag;
  logic             last_carry;
  logic [3:0]       last_cry_b;
  logic [8:0]       e;
  logic [4:0]       lo_sum;
`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
  logic             last_zero;
`endif

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_cmd_ready", 32'(cmd_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      busy = 1'b0;
    end else if (!busy) begin
      chk("idle_cmd_ready", 32'(cmd_ready), 1);
      chk("idle_rsp_valid", 32'(rsp_valid), 0);
      chk("idle_alu", 32'({alu_a, alu_b, alu_mode}), 0);
`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
      chk("idle_zero", 32'(rsp_zero), 0);
`endif
      if (cmd_valid) begin
        busy = 1'b1; seen = 1'b0;
        acc_cyc = cyc + 1;
        ca = cmd_a; cb = cmd_b; cm = cmd_mode; ct = cmd_tag;
        n_acc++;
      end
    end else begin
      k   = cyc - acc_cyc;
      lat = (cm == 2'b00) ? 3 : 2;
      e   = model(ca, cb, cm);
      lo_sum = {1'b0, ca[3:0]} + {1'b0, cb[3:0]};
      chk("busy_cmd_ready", 32'(cmd_ready), 0);
      chk("rsp_valid_timing", 32'(rsp_valid), 32'(k >= lat));
      if (k == 0)
        chk("alu_lo", 32'({alu_a, alu_b, alu_mode}), 32'({ca[3:0], cb[3:0], cm}));
      else if (k == 1)
        chk("alu_hi", 32'({alu_a, alu_b, alu_mode}), 32'({ca[7:4], cb[7:4], cm}));
      else if (k == 2 && cm == 2'b00) begin
        chk("alu_cry", 32'({alu_a, alu_b, alu_mode}),
            32'({4'(ca[7:4] + cb[7:4]), 3'b000, lo_sum[4], 2'b00}));
        last_cry_b = alu_b;
      end else
        chk("alu_rsp", 32'({alu_a, alu_b, alu_mode}), 0);
      if (rsp_valid) begin
        chk("rsp_result", 32'(rsp_result), 32'(e[7:0]));
        chk("rsp_carry", 32'(rsp_carry), 32'(e[8]));
        chk("rsp_tag", 32'(rsp_tag), 32'(ct));
`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
        chk("rsp_zero", 32'(rsp_zero), 32'(e[7:0] == 8'h00));
`endif
        if (!seen) begin last_lat = k; seen = 1'b1; end
        if (rsp_ready) begin
          last_res = rsp_result; last_carry = rsp_carry; last_tag = rsp_tag;
`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
          last_zero = rsp_zero;
`endif
          hs_cyc = cyc + 1;
          n_rsp++;
          busy = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m, input logic [TAG_W-1:0] t);
    int start, n;
    start = n_acc; n = 0;
    cmd_a = a; cmd_b = b; cmd_mode = m; cmd_tag = t; cmd_valid = 1'b1;
    while (n_acc == start && n < 300) begin @(posedge clk); #1; n++; end
    cmd_valid = 1'b0;
    if (n_acc == start) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int start);
    int n;
    n = 0;
    while (n_rsp == start && n < 300) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    if (n_rsp == start) chk("rsp_timeout", 0, 1);
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m, input logic [TAG_W-1:0] t);
    int s;
    s = n_rsp;
    send(a, b, m, t);
    wait_rsp(s);
  endtask

  initial begin
    int s, n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: ADD with low-nibble carry
    run(8'h3A, 8'h47, 2'b00, 2'b01);
    chk("t1_res", 32'(last_res), 32'h81);
    chk("t1_carry", 32'(last_carry), 0);
    chk("t1_tag", 32'(last_tag), 1);
    chk("t1_lat", last_lat, 3);
    chk("t1_cry_b", 32'(last_cry_b), 1);

    // 2: carry out of bit 7
    run(8'hFF, 8'h01, 2'b00, 2'b10);
    chk("t2a_res", 32'(last_res), 0);
    chk("t2a_carry", 32'(last_carry), 1);
`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
    chk("t2a_zero", 32'(last_zero), 1);
`endif
    run(8'h80, 8'h80, 2'b00, 2'b11);
    chk("t2b_res", 32'(last_res), 0);
    chk("t2b_carry", 32'(last_carry), 1);

    // 3: logic ops
    run(8'hF0, 8'h3C, 2'b01, 2'b00);
    chk("t3_and", 32'(last_res), 32'h30);
    chk("t3_and_lat", last_lat, 2);
    run(8'h0F, 8'hA0, 2'b10, 2'b01);
    chk("t3_or", 32'(last_res), 32'hAF);
    chk("t3_or_lat", last_lat, 2);
    chk("t3_or_carry", 32'(last_carry), 0);

    // 4: NOT ignores b
    run(8'h5A, 8'hFF, 2'b11, 2'b10);
    chk("t4_not_b_ff", 32'(last_res), 32'hA5);
    chk("t4_not_carry", 32'(last_carry), 0);
    run(8'h5A, 8'h00, 2'b11, 2'b10);
    chk("t4_not_b_00", 32'(last_res), 32'hA5);

    // 5: backpressure with a held second command
    rr_force = 1'b0;
    s = n_rsp;
    @(posedge clk); #1;
    send(8'h12, 8'h34, 2'b00, 2'b10);
    cmd_a = 8'hCC; cmd_b = 8'hAA; cmd_mode = 2'b01; cmd_tag = 2'b11; cmd_valid = 1'b1;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("t5_rsp_seen", 32'(rsp_valid), 1);
    repeat (5) @(negedge clk);
    rr_force = 1'b1;
    n = n_acc;
    s = 0;
    while (n_acc == n && s < 20) begin @(posedge clk); #1; s++; end
    cmd_valid = 1'b0;
    chk("t5_first_res", 32'(last_res), 32'h46);
    chk("t5_accept_after_hs", acc_cyc, hs_cyc + 1);
    wait_rsp(n_rsp);
    chk("t5_second_res", 32'(last_res), 32'h88);
    chk("t5_second_tag", 32'(last_tag), 3);

    // 6: reset during HI aborts the ADD
    send(8'h3A, 8'h47, 2'b00, 2'b01);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    s = n_rsp;
    repeat (8) @(negedge clk);
    chk("t6_no_stale_rsp", n_rsp, s);

    // random traffic
    rr_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(8'($urandom), 8'($urandom), 2'($urandom), TAG_W'($urandom));
    end
    wait_rsp(n_acc - 1 > n_rsp ? n_rsp : n_acc - 1);
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command-side driver for the 4-bit combinational `alu` block (inputs a/b/mode, output result; mode 00=ADD, 01=AND, 10=OR, 11=NOT a).
- Accepts 8-bit operations over a valid/ready command channel.
- Splits each operation into nibble passes through the external 4-bit ALU and derives the add carry chain.
- Returns the 8-bit result plus carry over a valid/ready response channel.
- Sits between the control logic and the ALU instance, turning the 4-bit datapath into an 8-bit one.

Parameters:
TAG_W, 2, width of the opaque command tag echoed unchanged on the response.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_a  input  8  operand A
cmd_b  input  8  operand B (ignored for NOT)
cmd_mode  input  2  00 ADD, 01 AND, 10 OR, 11 NOT A
cmd_tag  input  TAG_W  caller tag
alu_a  output  4  operand nibble to ALU
alu_b  output  4  operand nibble to ALU
alu_mode  output  2  mode to ALU
alu_result  input  4  ALU result (combinational from alu_a/alu_b/alu_mode)
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  8  operation result
rsp_carry  output  1  carry out of bit 7 (ADD only, else 0)
rsp_tag  output  TAG_W  tag of the completed command

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- States: IDLE, LO, HI, CRY, RSP.
- Reset (rst high at an edge): state <= IDLE; all holding registers cleared.
  - While rst is high: cmd_ready=0 and rsp_valid=0.
  - Reset mid-operation aborts the operation; no response is produced.
- Command handshake:
  - cmd_ready = (state==IDLE) && !rst.
  - Handshake when cmd_valid && cmd_ready at an edge: latch a, b, mode and tag; go to LO.
- ALU drive: alu_a, alu_b and alu_mode are combinational from the state and latched registers.
  - IDLE and RSP: drive 0, 0, 00.
- LO pass: alu_a=a[3:0], alu_b=b[3:0], alu_mode=mode.
  - At the edge: res[3:0] <= alu_result.
  - If ADD: c_lo <= (alu_result < a[3:0]).
  - Next state: HI.
- HI pass: alu_a=a[7:4], alu_b=b[7:4], alu_mode=mode.
  - At the edge: res[7:4] <= alu_result.
  - If ADD: c_hi <= (alu_result < a[7:4]), then go to CRY.
  - Otherwise go to RSP with carry 0.
- CRY pass (ADD only): alu_a=res[7:4], alu_b={3'b000,c_lo}, alu_mode=00.
  - At the edge: res[7:4] <= alu_result; carry <= c_hi | (alu_result < res[7:4]).
  - Next state: RSP.
- Latency from command acceptance edge to rsp_valid:
  - ADD: 3 cycles.
  - AND, OR, NOT: 2 cycles.
- Response handshake:
  - rsp_valid = (state==RSP).
  - rsp_result, rsp_carry and rsp_tag are registered and stable while rsp_valid && !rsp_ready.
  - Handshake (rsp_valid && rsp_ready) at an edge: go to IDLE.
  - A new command can be accepted at the earliest on the following edge; back-to-back throughput is one command per latency+1 cycles.
- Boundary conditions:
  - cmd_valid asserted while busy: ignored; the caller must hold it.
  - rsp_ready high before rsp_valid: no effect.
  - NOT ignores cmd_b completely.
  - Arithmetic wraps modulo 256; overflow is reported only via rsp_carry.

Optional Feature:
Macro: ALU_OP_SEQUENCER_ZERO_FLAG_EN.
- Defined: adds output port `rsp_zero` (1 bit), registered with the response and high iff rsp_result==8'h00. It is 0 at reset and outside RSP.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. ADD 8'h3A+8'h47, tag 2'b01 -> rsp_valid exactly 3 cycles after acceptance; rsp_result 8'h81, rsp_carry 0, rsp_tag 2'b01; alu_b=4'h1 during CRY.
2. ADD 8'hFF+8'h01 -> rsp_result 8'h00, rsp_carry 1; rsp_zero 1 when the macro is defined. Also ADD 8'h80+8'h80 -> 8'h00, carry 1 (c_hi path).
3. AND 8'hF0&8'h3C -> 8'h30; OR 8'h0F|8'hA0 -> 8'hAF. Each has rsp_valid 2 cycles after acceptance, rsp_carry 0, and no CRY pass (alu_mode never forced to 00).
4. NOT a=8'h5A, b=8'hFF -> 8'hA5, carry 0; repeat with b=8'h00 -> identical result.
5. Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_result, rsp_carry and rsp_tag stable; cmd_ready 0; a held second command is accepted only on the edge after the rsp handshake.
6. Assert rst for 1 cycle while in HI during an ADD -> next cycle state IDLE, rsp_valid 0, cmd_ready 1, alu_* 0; no stale response ever appears.
